// File: rtl/angle_zone_indexer_if.sv
// Host-side bundle for the angle zone indexer: request fields driven by the
// command parser, result fields consumed by the point-packet framer.
//
// Handshake: i_start is a single-cycle request, accepted only while o_busy is
// low. Once accepted, o_busy stays high through the cycle in which o_done
// pulses. All result fields change together in that o_done cycle and hold
// until the next o_done.
interface angle_zone_indexer_if #(
   parameter int ZONES   = 4,
   parameter int ANGLE_W = 32,
   parameter int IDX_W   = 16
);
   logic                     i_start;
   logic                     i_round;
   logic                     i_wrap_en;
   logic [IDX_W-1:0]         i_angle_reso;
   logic [ZONES*ANGLE_W-1:0] i_start_angle;
   logic [ZONES*ANGLE_W-1:0] i_stop_angle;
   logic [ZONES*IDX_W-1:0]   o_start_index;
   logic [ZONES*IDX_W-1:0]   o_stop_index;
   logic [ZONES*IDX_W-1:0]   o_index_num;
   logic [IDX_W-1:0]         o_index_max;
   logic [ZONES-1:0]         o_err;
   logic                     o_busy;
   logic                     o_done;

   modport master (
      output i_start, i_round, i_wrap_en, i_angle_reso, i_start_angle, i_stop_angle,
      input  o_start_index, o_stop_index, o_index_num, o_index_max, o_err, o_busy, o_done
   );

   modport slave (
      input  i_start, i_round, i_wrap_en, i_angle_reso, i_start_angle, i_stop_angle,
      output o_start_index, o_stop_index, o_index_num, o_index_max, o_err, o_busy, o_done
   );
endinterface

// File: rtl/angle_zone_indexer.sv
// Converts ZONES start/stop angle pairs into scan-point indices using one
// shared serial restoring divider. Results collect in shadow registers and
// are published together in the o_done cycle.
module angle_zone_indexer #(
   parameter int ZONES      = 4,
   parameter int ANGLE_W    = 32,
   parameter int IDX_W      = 16,
   parameter int OFFSET     = 900000,
   parameter int FULL_SCALE = 3600000,
   parameter int RST_STOP   = 3600
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   angle_zone_indexer_if.slave  bus,
   output logic [2:0]           o_dbg_state
);

   localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
   localparam int CW = $clog2(ANGLE_W + 1);
   localparam int NW = IDX_W + 2;
   localparam logic [ANGLE_W-1:0] IDX_ALL = {{(ANGLE_W-IDX_W){1'b0}}, {IDX_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_DIV_MAX, S_DIV_START, S_DIV_STOP, S_COUNT, S_DONE
   } state_t;

   state_t                   r_state;
   logic [CW-1:0]            r_cnt;
   logic [ZW-1:0]            r_zone;
   logic [IDX_W-1:0]         r_reso;
   logic                     r_round;
   logic                     r_wrap;
   logic [ZONES*ANGLE_W-1:0] r_start_ang;
   logic [ZONES*ANGLE_W-1:0] r_stop_ang;
   logic [ANGLE_W-1:0]       r_dvd;
   logic [IDX_W-1:0]         r_rem;
   logic                     r_neg;
   logic [IDX_W-1:0]         r_idx_max;
   logic [IDX_W-1:0]         r_sh_start [ZONES];
   logic [IDX_W-1:0]         r_sh_stop  [ZONES];
   logic [IDX_W-1:0]         r_sh_num   [ZONES];
   logic [ZONES-1:0]         r_sh_err;

   logic [ANGLE_W-1:0]       w_sel_ang;
   logic [ANGLE_W-1:0]       w_a;
   logic [ANGLE_W-1:0]       w_half;
   logic [ANGLE_W-1:0]       w_load_dvd;
   logic [IDX_W:0]           w_rem_sh;
   logic                     w_ge;
   logic [IDX_W-1:0]         w_rem_nx;
   logic [ANGLE_W-1:0]       w_q;
   logic [ANGLE_W-1:0]       w_lim;
   logic [IDX_W-1:0]         w_idx;
   logic [IDX_W-1:0]         w_max_q;
   logic [NW-1:0]            w_cs;
   logic [NW-1:0]            w_ce;
   logic [NW-1:0]            w_mx;
   logic [NW-1:0]            w_num_raw;
   logic [IDX_W-1:0]         w_num;

   assign o_dbg_state = r_state;

   // Divider datapath: dividend selection at load, one restoring step per cycle,
   // and the clamped index that a finishing division writes back.
   always_comb begin
      w_sel_ang  = (r_state == S_DIV_STOP) ? r_stop_ang[r_zone*ANGLE_W +: ANGLE_W]
                                           : r_start_ang[r_zone*ANGLE_W +: ANGLE_W];
      w_a        = w_sel_ang + ANGLE_W'(OFFSET);
      w_half     = r_round ? ANGLE_W'(r_reso >> 1) : '0;
      w_load_dvd = (r_state == S_DIV_MAX) ? ANGLE_W'(FULL_SCALE) : (w_a + w_half);
      w_rem_sh   = {r_rem, r_dvd[ANGLE_W-1]};
      w_ge       = (w_rem_sh >= {1'b0, r_reso});
      w_rem_nx   = w_ge ? (w_rem_sh[IDX_W-1:0] - r_reso) : w_rem_sh[IDX_W-1:0];
      w_q        = {r_dvd[ANGLE_W-2:0], w_ge};
      w_lim      = {{(ANGLE_W-IDX_W){1'b0}}, r_idx_max} - ANGLE_W'(1);
      if (r_neg) begin
         w_idx = '0;
      end else if (w_q > w_lim) begin
         w_idx = r_idx_max - IDX_W'(1);
      end else begin
         w_idx = w_q[IDX_W-1:0];
      end
      // points per revolution saturates if it cannot be represented
      w_max_q = (w_q > IDX_ALL) ? {IDX_W{1'b1}} : w_q[IDX_W-1:0];
   end

   // Point count for the current zone, including the legacy non-wrapping case.
   always_comb begin
      w_cs = NW'(r_sh_start[r_zone]);
      w_ce = NW'(r_sh_stop[r_zone]);
      w_mx = NW'(r_idx_max);
      if (w_ce >= w_cs) begin
         w_num_raw = w_ce - w_cs + NW'(1);
      end else if (r_wrap) begin
         w_num_raw = w_mx - w_cs + w_ce + NW'(1);
      end else begin
         w_num_raw = w_cs - w_ce + NW'(1);
      end
      w_num = (w_num_raw > w_mx) ? r_idx_max : w_num_raw[IDX_W-1:0];
   end

   // Control FSM, snapshot/shadow registers and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state           <= S_IDLE;
         r_cnt             <= '0;
         r_zone            <= '0;
         r_reso            <= '0;
         r_round           <= 1'b0;
         r_wrap            <= 1'b0;
         r_start_ang       <= '0;
         r_stop_ang        <= '0;
         r_dvd             <= '0;
         r_rem             <= '0;
         r_neg             <= 1'b0;
         r_idx_max         <= '0;
         r_sh_err          <= '0;
         for (int z = 0; z < ZONES; z++) begin
            r_sh_start[z]                     <= '0;
            r_sh_stop[z]                      <= '0;
            r_sh_num[z]                       <= '0;
            bus.o_start_index[z*IDX_W +: IDX_W] <= '0;
            bus.o_stop_index[z*IDX_W +: IDX_W]  <= IDX_W'(RST_STOP);
            bus.o_index_num[z*IDX_W +: IDX_W]   <= IDX_W'(RST_STOP);
         end
         bus.o_index_max   <= IDX_W'(RST_STOP);
         bus.o_err         <= '0;
         bus.o_busy        <= 1'b0;
         bus.o_done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               bus.o_done <= 1'b0;
               bus.o_busy <= bus.i_start;
               if (bus.i_start) begin
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_reso      <= bus.i_angle_reso;
               r_round     <= bus.i_round;
               r_wrap      <= bus.i_wrap_en;
               r_start_ang <= bus.i_start_angle;
               r_stop_ang  <= bus.i_stop_angle;
               r_zone      <= '0;
               r_cnt       <= '0;
               if (bus.i_angle_reso == '0) begin
                  // illegal resolution: publish an all-zero, all-error result
                  r_idx_max <= '0;
                  r_sh_err  <= '1;
                  for (int z = 0; z < ZONES; z++) begin
                     r_sh_start[z] <= '0;
                     r_sh_stop[z]  <= '0;
                     r_sh_num[z]   <= '0;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_sh_err <= '0;
                  r_state  <= S_DIV_MAX;
               end
            end
            S_DIV_MAX, S_DIV_START, S_DIV_STOP: begin
               if (r_cnt == '0) begin
                  r_dvd <= w_load_dvd;
                  r_rem <= '0;
                  r_neg <= (r_state != S_DIV_MAX) && w_a[ANGLE_W-1];
                  r_cnt <= CW'(1);
               end else begin
                  r_dvd <= w_q;
                  r_rem <= w_rem_nx;
                  if (r_cnt == CW'(ANGLE_W)) begin
                     r_cnt <= '0;
                     if (r_state == S_DIV_MAX) begin
                        r_idx_max <= w_max_q;
                        r_state   <= S_DIV_START;
                     end else if (r_state == S_DIV_START) begin
                        r_sh_start[r_zone] <= w_idx;
                        r_sh_err[r_zone]   <= r_neg;
                        r_state            <= S_DIV_STOP;
                     end else begin
                        r_sh_stop[r_zone] <= w_idx;
                        if (r_neg) begin
                           r_sh_err[r_zone] <= 1'b1;
                        end
                        r_state <= S_COUNT;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_COUNT: begin
               r_sh_num[r_zone] <= w_num;
               if (r_zone == ZW'(ZONES - 1)) begin
                  r_state <= S_DONE;
               end else begin
                  r_zone  <= r_zone + ZW'(1);
                  r_state <= S_DIV_START;
               end
            end
            S_DONE: begin
               for (int z = 0; z < ZONES; z++) begin
                  bus.o_start_index[z*IDX_W +: IDX_W] <= r_sh_start[z];
                  bus.o_stop_index[z*IDX_W +: IDX_W]  <= r_sh_stop[z];
                  bus.o_index_num[z*IDX_W +: IDX_W]   <= r_sh_num[z];
               end
               bus.o_index_max <= r_idx_max;
               bus.o_err       <= r_sh_err;
               bus.o_done      <= 1'b1;
               r_state         <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_angle_zone_indexer.sv
// Directed bench for angle_zone_indexer: linear sequence of runs with
// hand-computed indices, counts, latencies and reset behaviour.
module tb_angle_zone_indexer;

   localparam int ZONES   = 4;
   localparam int ANGLE_W = 32;
   localparam int IDX_W   = 16;

   logic       i_clk;
   logic       i_rst;
   logic [2:0] dbg_state;

   int total;
   int bad;
   int lat;
   int pulses;
   logic saw_busy;
   logic [ZONES*IDX_W-1:0] mid_num;

   angle_zone_indexer_if #(.ZONES(ZONES), .ANGLE_W(ANGLE_W), .IDX_W(IDX_W)) bus ();

   angle_zone_indexer dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fld(input logic [ZONES*IDX_W-1:0] v, input int z);
      logic [IDX_W-1:0] f;
      f = v[z*IDX_W +: IDX_W];
      return {16'd0, f};
   endfunction

   // Pulse i_start, then watch a fixed window of cycles. lat is the edge count
   // (start sample edge = 0) at which o_done is first seen; 0 means never.
   task automatic run(input int poke_at, input int rst_at);
      bus.i_start = 1'b1;
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
      lat = 0; pulses = 0; saw_busy = 1'b0;
      for (int k = 1; k <= 420; k++) begin
         @(posedge i_clk); #1;
         bus.i_start = (k == poke_at);
         if (k == rst_at)     i_rst = 1'b1;
         if (k == rst_at + 3) i_rst = 1'b0;
         if (k == 100) saw_busy = bus.o_busy;
         if (k == 302) mid_num = bus.o_index_num;
         if (bus.o_done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = k;
         end
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      for (int z = 0; z < ZONES; z++) begin
         chk({pfx, "_start"}, fld(bus.o_start_index, z), 32'd0);
         chk({pfx, "_stop"},  fld(bus.o_stop_index, z),  32'd3600);
         chk({pfx, "_num"},   fld(bus.o_index_num, z),   32'd3600);
      end
      chk({pfx, "_max"},   {16'd0, bus.o_index_max}, 32'd3600);
      chk({pfx, "_err"},   {28'd0, bus.o_err},       32'd0);
      chk({pfx, "_busy"},  {31'd0, bus.o_busy},      32'd0);
      chk({pfx, "_done"},  {31'd0, bus.o_done},      32'd0);
      chk({pfx, "_state"}, {29'd0, dbg_state},       32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      i_rst = 1'b1;
      bus.i_start       = 1'b0;
      bus.i_round       = 1'b0;
      bus.i_wrap_en     = 1'b0;
      bus.i_angle_reso  = 16'd1000;
      bus.i_start_angle = '0;
      bus.i_stop_angle  = '0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(posedge i_clk); #1;
      check_reset_vals("rst");

      // zone0 -45..225, zone1 -100..400, zone2 180..45 wrapping, zone3 0..0
      bus.i_start_angle[0*32 +: 32] = 32'hFFF92230;
      bus.i_stop_angle[0*32 +: 32]  = 32'h00225510;
      bus.i_start_angle[1*32 +: 32] = -32'sd1000000;
      bus.i_stop_angle[1*32 +: 32]  = 32'sd4000000;
      bus.i_start_angle[2*32 +: 32] = 32'sd1800000;
      bus.i_stop_angle[2*32 +: 32]  = 32'sd450000;
      bus.i_wrap_en = 1'b1;
      run(50, -10);
      chk("t1_lat",      lat, 32'd303);
      chk("t1_pulses",   pulses, 32'd1);
      chk("t1_busy_mid", {31'd0, saw_busy}, 32'd1);
      chk("t1_z0_start", fld(bus.o_start_index, 0), 32'd450);
      chk("t1_z0_stop",  fld(bus.o_stop_index, 0),  32'd3150);
      chk("t1_z0_num",   fld(bus.o_index_num, 0),   32'd2701);
      chk("t1_max",      {16'd0, bus.o_index_max},  32'd3600);
      chk("t1_err",      {28'd0, bus.o_err},        32'd2);
      chk("t1_z1_start", fld(bus.o_start_index, 1), 32'd0);
      chk("t1_z1_stop",  fld(bus.o_stop_index, 1),  32'd3599);
      chk("t1_z1_num",   fld(bus.o_index_num, 1),   32'd3600);
      chk("t1_z2_start", fld(bus.o_start_index, 2), 32'd2700);
      chk("t1_z2_stop",  fld(bus.o_stop_index, 2),  32'd1350);
      chk("t1_z2_num",   fld(bus.o_index_num, 2),   32'd2251);
      chk("t1_z3_start", fld(bus.o_start_index, 3), 32'd900);
      chk("t1_z3_num",   fld(bus.o_index_num, 3),   32'd1);
      chk("t1_busy_end", {31'd0, bus.o_busy}, 32'd0);

      // same windows without wrap: zone2 falls back to the legacy count
      bus.i_wrap_en = 1'b0;
      run(-10, -10);
      chk("t2_lat",      lat, 32'd303);
      chk("t2_hold_num", fld(mid_num, 2), 32'd2251);
      chk("t2_z2_num",   fld(bus.o_index_num, 2), 32'd1351);
      chk("t2_z0_num",   fld(bus.o_index_num, 0), 32'd2701);

      // reso 3333, floor then round-to-nearest on zone0 start 0.17 deg
      bus.i_angle_reso = 16'd3333;
      bus.i_start_angle[0*32 +: 32] = 32'sd1700;
      run(-10, -10);
      chk("t3_max",      {16'd0, bus.o_index_max},  32'd1080);
      chk("t3_z0_start", fld(bus.o_start_index, 0), 32'd270);
      chk("t3_z0_stop",  fld(bus.o_stop_index, 0),  32'd945);
      chk("t3_z0_num",   fld(bus.o_index_num, 0),   32'd676);
      bus.i_round = 1'b1;
      run(-10, -10);
      chk("t4_max",      {16'd0, bus.o_index_max},  32'd1080);
      chk("t4_z0_start", fld(bus.o_start_index, 0), 32'd271);
      chk("t4_z0_stop",  fld(bus.o_stop_index, 0),  32'd945);
      chk("t4_z0_num",   fld(bus.o_index_num, 0),   32'd675);

      // illegal resolution
      bus.i_round      = 1'b0;
      bus.i_angle_reso = 16'd0;
      run(-10, -10);
      chk("t5_lat",      lat, 32'd2);
      chk("t5_pulses",   pulses, 32'd1);
      chk("t5_z0_start", fld(bus.o_start_index, 0), 32'd0);
      chk("t5_z2_stop",  fld(bus.o_stop_index, 2),  32'd0);
      chk("t5_z1_num",   fld(bus.o_index_num, 1),   32'd0);
      chk("t5_max",      {16'd0, bus.o_index_max},  32'd0);
      chk("t5_err",      {28'd0, bus.o_err},        32'd15);

      // reset in the middle of a run aborts it
      bus.i_angle_reso = 16'd1000;
      run(-10, 150);
      chk("t6_pulses", pulses, 32'd0);
      check_reset_vals("t6");

      // normal run after the abort
      run(-10, -10);
      chk("t7_lat",      lat, 32'd303);
      chk("t7_z0_start", fld(bus.o_start_index, 0), 32'd901);
      chk("t7_z0_stop",  fld(bus.o_stop_index, 0),  32'd3150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
